// File: rtl/clk_pkg.sv
// clk_pkg: shared types and helpers for the clock divider bank.
//   WORD_WIDTH       width of the factor/high/counter words
//   CHANNELS_DEFAULT default number of divider channels
//   word_t           one divide word
//   chan_state_t     per-channel state: active F/H, counter, shadow F/H, pending
//   default_high()   fixed high time used when DUTY_EN is not defined
//   low_time()       low portion of a period, with H saturated at F
package clk_pkg;

  localparam int WORD_WIDTH       = 16;
  localparam int CHANNELS_DEFAULT = 4;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t WORD_ONE = word_t'(1);

  typedef struct packed {
    word_t f;
    word_t h;
    word_t cnt;
    word_t shadow_f;
    word_t shadow_h;
    logic  pending;
  } chan_state_t;

  // Low for floor(F/2) cycles, high for the remainder.
  function automatic word_t default_high(input word_t f);
    return f - (f >> 1);
  endfunction

  // H larger than F means the clock is high for the whole period.
  function automatic word_t low_time(input word_t f, input word_t h);
    return (h >= f) ? '0 : word_t'(f - h);
  endfunction

endpackage

// File: rtl/clk_divider_channel.sv
// clk_divider_channel: one programmable divider channel.
// Optional feature macro: DUTY_EN (adds the high_i input; otherwise the
// high time is derived from the factor via default_high()).
// Ports:
//   clk_i     system clock
//   reset     synchronous, active-high reset
//   enable_i  run enable; low clears the counter and the outputs
//   load_i    captures factor_i (and high_i) into the shadow registers
//   factor_i  requested period in clk_i cycles
//   high_i    requested high cycles per period (DUTY_EN only)
//   clk_o     divided clock, registered
//   tick_o    one-cycle pulse at the first cycle of each period, registered
//   pending_o a loaded value is waiting for a period boundary
module clk_divider_channel
  import clk_pkg::*;
(
  input  logic  clk_i,
  input  logic  reset,
  input  logic  enable_i,
  input  logic  load_i,
  input  word_t factor_i,
`ifdef DUTY_EN
  input  word_t high_i,
`endif
  output logic  clk_o,
  output logic  tick_o,
  output logic  pending_o
);

  chan_state_t state;
  chan_state_t state_next;
  logic        clk_next;
  logic        tick_next;
  logic        running;
  logic        wrap;
  logic        boundary;
  word_t       load_high;

`ifdef DUTY_EN
  assign load_high = high_i;
`else
  assign load_high = default_high(factor_i);
`endif

  // A boundary is either the last cycle of a running period or any cycle
  // where the channel is not running; only there may new values go active.
  // A load arriving on a boundary bypasses the shadow so pending never rises.
  always_comb begin
    state_next = state;
    clk_next   = 1'b0;
    tick_next  = 1'b0;
    running    = enable_i && (state.f != '0);
    wrap       = running && (state.cnt == word_t'(state.f - WORD_ONE));
    boundary   = wrap || !running;

    if (running) begin
      clk_next       = (state.cnt >= low_time(state.f, state.h));
      tick_next      = (state.cnt == '0);
      state_next.cnt = wrap ? '0 : word_t'(state.cnt + WORD_ONE);
    end else begin
      state_next.cnt = '0;
    end

    if (load_i) begin
      state_next.shadow_f = factor_i;
      state_next.shadow_h = load_high;
      if (boundary) begin
        state_next.f       = factor_i;
        state_next.h       = load_high;
        state_next.cnt     = '0;
        state_next.pending = 1'b0;
      end else begin
        state_next.pending = 1'b1;
      end
    end else if (state.pending && boundary) begin
      state_next.f       = state.shadow_f;
      state_next.h       = state.shadow_h;
      state_next.cnt     = '0;
      state_next.pending = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state  <= '0;
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      state  <= state_next;
      clk_o  <= clk_next;
      tick_o <= tick_next;
    end
  end

  assign pending_o = state.pending;

endmodule

// File: rtl/clk_divider_bank.sv
// clk_divider_bank: CHANNELS independent programmable clock dividers.
// Optional feature macro: DUTY_EN (adds the high_i port for programmable
// high time; otherwise each channel is low floor(F/2) cycles, then high).
// Parameters:
//   CHANNELS  number of divider channels (1..16)
//   WIDTH     factor/high word width; must equal clk_pkg::WORD_WIDTH
// Ports:
//   clk_i     system clock
//   reset     synchronous, active-high reset
//   enable_i  global run enable; low stops and clears all channel counters
//   load_i    per-channel load strobe
//   factor_i  per-channel requested period
//   high_i    per-channel requested high time (DUTY_EN only)
//   clk_o     per-channel divided clock
//   tick_o    per-channel period-start pulse
//   pending_o per-channel loaded-value-waiting flag
module clk_divider_bank
  import clk_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEFAULT,
  parameter int WIDTH    = WORD_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           reset,
  input  logic                           enable_i,
  input  logic [CHANNELS-1:0]            load_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0] factor_i,
`ifdef DUTY_EN
  input  logic [CHANNELS-1:0][WIDTH-1:0] high_i,
`endif
  output logic [CHANNELS-1:0]            clk_o,
  output logic [CHANNELS-1:0]            tick_o,
  output logic [CHANNELS-1:0]            pending_o
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    clk_divider_channel u_chan (
      .clk_i     (clk_i),
      .reset     (reset),
      .enable_i  (enable_i),
      .load_i    (load_i[n]),
      .factor_i  (factor_i[n]),
`ifdef DUTY_EN
      .high_i    (high_i[n]),
`endif
      .clk_o     (clk_o[n]),
      .tick_o    (tick_o[n]),
      .pending_o (pending_o[n])
    );
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// tb_clk_divider_bank: self-checking bench for clk_divider_bank.
// A period-origin model (position = elapsed edges modulo F) predicts every
// output each cycle; directed sequences pin hand-computed waveforms.
// Honours DUTY_EN the same way as the design.
`timescale 1ns/1ps
module tb_clk_divider_bank;

  localparam int CH = 4;
  localparam int W  = 16;

  logic                  clk_i = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [CH-1:0]         load;
  logic [CH-1:0][W-1:0]  factor;
`ifdef DUTY_EN
  logic [CH-1:0][W-1:0]  high;
`endif
  logic [CH-1:0]         clk_out;
  logic [CH-1:0]         tick_out;
  logic [CH-1:0]         pend_out;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_on     = 1'b0;

  always #5 clk_i = ~clk_i;

  clk_divider_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_i     (clk_i),
    .reset     (reset),
    .enable_i  (enable),
    .load_i    (load),
    .factor_i  (factor),
`ifdef DUTY_EN
    .high_i    (high),
`endif
    .clk_o     (clk_out),
    .tick_o    (tick_out),
    .pending_o (pend_out)
  );

  // Reference model: each channel keeps active F/H, shadow F/H, pending and
  // the edge index at which its current period alignment began.
  int            mf[CH];
  int            mh[CH];
  int            msf[CH];
  int            msh[CH];
  int            morg[CH];
  bit            mpend[CH];
  logic [CH-1:0] exp_clk  = '0;
  logic [CH-1:0] exp_tick = '0;
  logic [CH-1:0] exp_pend = '0;
  int            edge_idx = 0;

  task automatic modelStep();
    int pos;
    int f_in;
    int h_in;
    int hs;
    bit run;
    bit bnd;
    edge_idx++;
    for (int n = 0; n < CH; n++) begin
      if (reset) begin
        mf[n] = 0; mh[n] = 0; msf[n] = 0; msh[n] = 0;
        mpend[n] = 1'b0; morg[n] = edge_idx + 1;
        exp_clk[n] = 1'b0; exp_tick[n] = 1'b0;
      end else begin
        run = enable && (mf[n] > 0);
        pos = run ? (edge_idx - morg[n]) % mf[n] : 0;
        bnd = !run || (pos == mf[n] - 1);
        hs  = (mh[n] < mf[n]) ? mh[n] : mf[n];
        exp_clk[n]  = run && (pos >= mf[n] - hs);
        exp_tick[n] = run && (pos == 0);
        if (load[n]) begin
          f_in = int'(factor[n]);
`ifdef DUTY_EN
          h_in = int'(high[n]);
`else
          h_in = f_in - f_in / 2;
`endif
          msf[n] = f_in;
          msh[n] = h_in;
          if (bnd) begin
            mf[n] = f_in; mh[n] = h_in; mpend[n] = 1'b0; morg[n] = edge_idx + 1;
          end else begin
            mpend[n] = 1'b1;
          end
        end else if (mpend[n] && bnd) begin
          mf[n] = msf[n]; mh[n] = msh[n]; mpend[n] = 1'b0; morg[n] = edge_idx + 1;
        end else if (!run) begin
          morg[n] = edge_idx + 1;
        end
      end
      exp_pend[n] = mpend[n];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // ch < 0 drops all load strobes; otherwise loads factor f into channel ch
  // with the same high time the fixed-duty build would use.
  task automatic applyStimulus(input int ch, input int f);
    load = '0;
    if (ch >= 0) begin
      load[ch]   = 1'b1;
      factor[ch] = f[W-1:0];
`ifdef DUTY_EN
      high[ch]   = W'(f - f / 2);
`endif
    end
  endtask

  // Steps n cycles, checking channel ch against bit i of each pattern.
  task automatic checkPattern(input string name, input int ch, input int n,
                              input logic [7:0] pclk, input logic [7:0] ptick);
    for (int i = 0; i < n; i++) begin
      step(1);
      checkOutput({name, " clk"},  clk_out[ch],  pclk[i]);
      checkOutput({name, " tick"}, tick_out[ch], ptick[i]);
    end
  endtask

  initial begin
    modelLoop();
  end

  task automatic modelLoop();
    forever begin
      @(posedge clk_i);
      modelStep();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (check_on) begin
        checkOutput("model clk_o",     clk_out,  exp_clk);
        checkOutput("model tick_o",    tick_out, exp_tick);
        checkOutput("model pending_o", pend_out, exp_pend);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    load   = '0;
    factor = '0;
`ifdef DUTY_EN
    high   = '0;
`endif
    step(1);
    check_on = 1'b1;
    step(1);
    checkOutput("reset clk_o",     clk_out,  0);
    checkOutput("reset tick_o",    tick_out, 0);
    checkOutput("reset pending_o", pend_out, 0);
    reset = 1'b0;

    $display("[TB] load ch0 F=4 into stopped channel");
    applyStimulus(0, 4);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("load edge tick0", tick_out[0], 0);
    checkOutput("load edge pend0", pend_out[0], 0);
    checkPattern("F4", 0, 8, 8'b1100_1100, 8'b0001_0001);

    $display("[TB] switch F=4 -> F=6 at cnt=1");
    step(1);
    applyStimulus(0, 6);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("switch pend0 a", pend_out[0], 1);
    step(1);
    checkOutput("switch pend0 b", pend_out[0], 1);
    step(1);
    checkOutput("switch pend0 c", pend_out[0], 0);
    checkOutput("switch old tail clk0", clk_out[0], 1);
    checkPattern("F6", 0, 6, 8'b0011_1000, 8'b0000_0001);

    $display("[TB] load at the wrap cycle");
    step(5);
    applyStimulus(0, 4);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("wrap load pend0", pend_out[0], 0);
    checkOutput("wrap load clk0",  clk_out[0], 1);
    checkPattern("wrap F4", 0, 4, 8'b0000_1100, 8'b0000_0001);

    $display("[TB] two loads while pending, last wins");
    applyStimulus(0, 8);
    step(1);
    checkOutput("dbl pend0 a", pend_out[0], 1);
    applyStimulus(0, 2);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("dbl pend0 b", pend_out[0], 1);
    step(2);
    checkOutput("dbl pend0 c", pend_out[0], 0);
    checkPattern("F2", 0, 4, 8'b0000_1010, 8'b0000_0101);

    $display("[TB] F=1 and F=0 on ch3");
    applyStimulus(3, 1);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("F1 load tick3", tick_out[3], 0);
    checkPattern("F1", 3, 3, 8'b0000_0111, 8'b0000_0111);
    applyStimulus(3, 0);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("F0 load pend3", pend_out[3], 0);
    checkPattern("F0", 3, 2, 8'b0000_0000, 8'b0000_0000);

    $display("[TB] enable low for 3 cycles");
    enable = 1'b0;
    applyStimulus(1, 3);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("dis clk_o 1",  clk_out,  0);
    checkOutput("dis tick_o 1", tick_out, 0);
    checkOutput("dis pend1",    pend_out[1], 0);
    step(1);
    checkOutput("dis clk_o 2",  clk_out,  0);
    step(1);
    checkOutput("dis tick_o 3", tick_out, 0);
    enable = 1'b1;
    step(1);
    checkOutput("restart tick_o 0", tick_out, 4'b0011);
    checkOutput("restart clk_o 0",  clk_out,  4'b0000);
    step(1);
    checkOutput("restart tick_o 1", tick_out, 4'b0000);
    checkOutput("restart clk_o 1",  clk_out,  4'b0011);
    step(1);
    checkOutput("restart tick_o 2", tick_out, 4'b0001);
    checkOutput("restart clk_o 2",  clk_out,  4'b0010);

    $display("[TB] reset mid-pending on ch2");
    applyStimulus(2, 5);
    step(1);
    applyStimulus(-1, 0);
    step(1);
    applyStimulus(2, 3);
    step(1);
    applyStimulus(-1, 0);
    checkOutput("pre-reset pend2", pend_out[2], 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("mid reset clk_o",     clk_out,  0);
    checkOutput("mid reset tick_o",    tick_out, 0);
    checkOutput("mid reset pending_o", pend_out, 0);
    step(3);
    checkOutput("post reset clk_o",  clk_out,  0);
    checkOutput("post reset tick_o", tick_out, 0);

`ifdef DUTY_EN
    $display("[TB] programmable duty on ch1");
    load = 4'b0010; factor[1] = 16'd5; high[1] = 16'd1;
    step(1);
    load = '0;
    checkPattern("H1", 1, 5, 8'b0001_0000, 8'b0000_0001);
    load = 4'b0010; factor[1] = 16'd5; high[1] = 16'd9;
    step(1);
    load = '0;
    checkOutput("H9 pend1", pend_out[1], 1);
    step(4);
    checkPattern("H9", 1, 5, 8'b0001_1111, 8'b0000_0001);
    load = 4'b0010; factor[1] = 16'd5; high[1] = 16'd0;
    step(1);
    load = '0;
    step(4);
    checkPattern("H0", 1, 5, 8'b0000_0000, 8'b0000_0001);
`endif

    step(2);
    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Multi-channel programmable clock divider for the Uniboard. Produces CHANNELS independent divided clock enables/strobes from clk_i. Each channel has a runtime-programmable divide factor, a programmable high time, and a per-period tick pulse. Factor changes take effect only at a period boundary, so outputs never glitch. Feeds PWM, UART baud and sensor-sampling logic from one place.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 16, width of factor/high words; max period 2^WIDTH-1 cycles
- clk_i  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable_i  in  1  global run enable; low stops and clears all channel counters
- load_i  in  CHANNELS  per-channel load strobe; captures factor_i/high_i for that channel
- factor_i  in  CHANNELS x WIDTH  requested period in clk_i cycles
- high_i  in  CHANNELS x WIDTH  requested high cycles per period (DUTY_EN only)
- clk_o  out  CHANNELS  divided clock, registered
- tick_o  out  CHANNELS  one-cycle pulse at the first cycle of each period, registered
- pending_o  out  CHANNELS  high while a loaded value waits for a period boundary

## Operation
- Per channel: active factor F, active high H, counter cnt (0..F-1), shadow F/H, pending flag.
- Low time L = F - H; H > F saturates to H = F (always high); H = 0 gives always low.
- Each enabled cycle with F >= 1: clk_o <= (cnt >= L); tick_o <= (cnt == 0); cnt <= (cnt == F-1) ? 0 : cnt+1.
- F = 0: channel stopped; cnt held 0, clk_o = 0, tick_o = 0.
- F = 1: clk_o follows H (high if H >= 1), tick_o asserted every cycle.
- load_i[n]: shadow <= factor_i/high_i, pending <= 1. Repeat load while pending overwrites shadow; last wins.
- Apply (active <= shadow, cnt <= 0, pending <= 0) on the edge where cnt == F-1 and pending is set, or on the first edge after the load if the channel is stopped (F = 0) or enable_i is low.
- Load coincident with the wrap edge (cnt == F-1): applies at that same edge (bypass), pending_o never asserts.
- enable_i low: cnt <= 0, clk_o <= 0, tick_o <= 0; loads still accepted and applied immediately. On enable_i rising, all channels start at cnt 0, phase-aligned.
- Channels are fully independent apart from enable_i and reset.

## Timing
- Reset: cnt 0, active F/H 0, shadow 0, clk_o 0, tick_o 0, pending_o 0 on all channels.
- Reset mid-period or mid-pending: discards everything, returns to reset state on the next edge.
- Load into stopped channel at edge N: active updated at N, first tick_o and first clk_o value at edge N+1.
- clk_o/tick_o lag cnt by one register stage; period exactly F cycles; clk_o high exactly H cycles per period, at the end of the period.
- Switch between running factors: last old period completes fully; new period's tick_o is the cycle after the old period's final cycle. No runt or stretched pulses.

## Configuration
- DUTY_EN defined: high_i port present, H programmable as above.
- DUTY_EN undefined: high_i port absent; H = F - (F >> 1) (low for floor(F/2) cycles, then high), fixed per factor.

## Structure
- Package clk_pkg: typedef for the WIDTH-wide divide word, CHANNELS default, channel state struct (F, H, cnt, shadow, pending).
- Sub-module clk_divider_channel holds one channel's counter, shadow and apply logic; the top generates CHANNELS instances and shares enable_i/reset.

## Test plan
- Reset, load ch0 F=4 (H=2 / default) -> clk_o[0] 0,0,1,1 repeating, tick_o[0] every 4th cycle, first tick one edge after load.
- DUTY_EN: ch1 F=5, H=1 -> clk_o 0,0,0,0,1; H=9 -> constantly high; H=0 -> constantly low, ticks still every 5.
- ch0 running F=4, load F=6 at cnt=1 -> pending_o high 2 cycles, old period completes, then 6-cycle periods, no glitch.
- Load at the wrap cycle (cnt=3, F=4) -> new F applies at that edge, pending_o stays 0; two loads while pending -> only the second applies.
- F=1 -> tick_o every cycle; F=0 -> clk_o and tick_o stay 0; enable_i low for 3 cycles -> all outputs 0, restart aligned at cnt 0.
- Assert reset mid-pending on ch2 -> next edge all outputs and pending_o 0, channel stopped until reloaded.
